// File: rtl/cnn_pkg.sv
// Project-wide constants shared by the CNN front-end blocks.
package cnn_pkg;

  // Downsampler modes
  localparam int MODE_DECIM = 0;
  localparam int MODE_MAX   = 1;

  // Counter width for a 0..n-1 range, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_downsample_if.sv
// Pixel stream in / downsampled stream out for pool_downsample.
interface pool_downsample_if #(
  parameter int DATA_W = 1
);
  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic              in_sof;
  logic [DATA_W-1:0] down_data;
  logic              down_data_vld;
  logic              down_eof;

  // Pixel source / result sink side
  modport master (
    output in_data, in_vld, in_sof,
    input  down_data, down_data_vld, down_eof
  );

  // Downsampler side
  modport slave (
    input  in_data, in_vld, in_sof,
    output down_data, down_data_vld, down_eof
  );
endinterface

// File: rtl/pool_downsample_raster_pos_cnt.sv
// Raster position tracker: column/row phase inside a window and block index.
// The outputs describe the pixel presented this cycle; a start-of-frame
// forces them to (0,0) so the pixel is handled as the first of a new frame.
module raster_pos_cnt
  import cnn_pkg::*;
#(
  parameter  int IMG_W  = 112,
  parameter  int IMG_H  = 112,
  parameter  int FACTOR = 4,
  localparam int PH_W   = clog2_min1(FACTOR),
  localparam int CB_W   = clog2_min1(IMG_W / FACTOR),
  localparam int RB_W   = clog2_min1(IMG_H / FACTOR)
) (
  input  logic            sclk,
  input  logic            s_rst_n,
  input  logic            adv,
  input  logic            sof,
  output logic [PH_W-1:0] col_ph,
  output logic [CB_W-1:0] col_blk,
  output logic [PH_W-1:0] row_ph,
  output logic [RB_W-1:0] row_blk,
  output logic            win_first,
  output logic            win_last,
  output logic            frame_last
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(FACTOR - 1);
  localparam logic [CB_W-1:0] CB_LAST = CB_W'(IMG_W / FACTOR - 1);
  localparam logic [RB_W-1:0] RB_LAST = RB_W'(IMG_H / FACTOR - 1);

  logic [PH_W-1:0] col_ph_reg, col_ph_next;
  logic [CB_W-1:0] col_blk_reg, col_blk_next;
  logic [PH_W-1:0] row_ph_reg, row_ph_next;
  logic [RB_W-1:0] row_blk_reg, row_blk_next;

  assign col_ph  = sof ? '0 : col_ph_reg;
  assign col_blk = sof ? '0 : col_blk_reg;
  assign row_ph  = sof ? '0 : row_ph_reg;
  assign row_blk = sof ? '0 : row_blk_reg;

  assign win_first  = (col_ph == '0) && (row_ph == '0);
  assign win_last   = (col_ph == PH_LAST) && (row_ph == PH_LAST);
  assign frame_last = (col_blk == CB_LAST) && (row_blk == RB_LAST);

  // Position of the pixel following the current one (cascaded wrap)
  always_comb begin
    col_ph_next  = col_ph;
    col_blk_next = col_blk;
    row_ph_next  = row_ph;
    row_blk_next = row_blk;
    if (col_ph == PH_LAST) begin
      col_ph_next = '0;
      if (col_blk == CB_LAST) begin
        col_blk_next = '0;
        if (row_ph == PH_LAST) begin
          row_ph_next  = '0;
          row_blk_next = (row_blk == RB_LAST) ? '0 : row_blk + 1'b1;
        end else begin
          row_ph_next = row_ph + 1'b1;
        end
      end else begin
        col_blk_next = col_blk + 1'b1;
      end
    end else begin
      col_ph_next = col_ph + 1'b1;
    end
  end

  // Counters move only on valid pixels and hold through gaps
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      col_ph_reg  <= '0;
      col_blk_reg <= '0;
      row_ph_reg  <= '0;
      row_blk_reg <= '0;
    end else if (adv) begin
      col_ph_reg  <= col_ph_next;
      col_blk_reg <= col_blk_next;
      row_ph_reg  <= row_ph_next;
      row_blk_reg <= row_blk_next;
    end
  end

endmodule

// File: rtl/pool_downsample.sv
// Spatial downsampler by FACTOR in x and y: top-left decimation or max-pool.
module pool_downsample
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 112,
  parameter int IMG_H  = 112,
  parameter int FACTOR = 4,
  parameter int DATA_W = 1,
  parameter int MODE   = MODE_DECIM
) (
  input  logic               sclk,
  input  logic               s_rst_n,
  pool_downsample_if.slave   bus
);

  localparam int PH_W = clog2_min1(FACTOR);
  localparam int CB_W = clog2_min1(IMG_W / FACTOR);
  localparam int RB_W = clog2_min1(IMG_H / FACTOR);
  localparam int NBLK = IMG_W / FACTOR;

  logic [PH_W-1:0]   col_ph;
  logic [CB_W-1:0]   col_blk;
  logic [PH_W-1:0]   row_ph;
  logic [RB_W-1:0]   row_blk;
  logic              win_first;
  logic              win_last;
  logic              frame_last;

  logic              emit_vld;
  logic [DATA_W-1:0] emit_data;

  logic [DATA_W-1:0] down_data_reg;
  logic              down_data_vld_reg;
  logic              down_eof_reg;
  logic              unused_pos;

  raster_pos_cnt #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .FACTOR (FACTOR)
  ) u_pos (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .adv        (bus.in_vld),
    .sof        (bus.in_sof & bus.in_vld),
    .col_ph     (col_ph),
    .col_blk    (col_blk),
    .row_ph     (row_ph),
    .row_blk    (row_blk),
    .win_first  (win_first),
    .win_last   (win_last),
    .frame_last (frame_last)
  );

  // Phases are consumed through the window flags only
  assign unused_pos = ^{col_ph, row_ph, row_blk, col_blk, win_last};

  generate
    if (MODE == MODE_MAX) begin : g_max
      logic [DATA_W-1:0] acc [0:NBLK-1];
      logic [DATA_W-1:0] acc_rd;
      logic [DATA_W-1:0] pix_max;

      assign acc_rd  = acc[col_blk];
      assign pix_max = (acc_rd > bus.in_data) ? acc_rd : bus.in_data;

      // Running window maximum per output column; first window pixel reloads
      always_ff @(posedge sclk) begin
        if (bus.in_vld) begin
          acc[col_blk] <= win_first ? bus.in_data : pix_max;
        end
      end

      assign emit_vld  = bus.in_vld & win_last;
      assign emit_data = pix_max;
    end else begin : g_decim
      assign emit_vld  = bus.in_vld & win_first;
      assign emit_data = bus.in_data;
    end
  endgenerate

  // Registered output; data forced to zero outside valid pulses
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      down_data_reg     <= '0;
      down_data_vld_reg <= 1'b0;
      down_eof_reg      <= 1'b0;
    end else begin
      down_data_reg     <= emit_vld ? emit_data : '0;
      down_data_vld_reg <= emit_vld;
      down_eof_reg      <= emit_vld & frame_last;
    end
  end

  assign bus.down_data     = down_data_reg;
  assign bus.down_data_vld = down_data_vld_reg;
  assign bus.down_eof      = down_eof_reg;

endmodule
